// File: rtl/wbi_burst_splitter.sv
// ---------------------------------------------------------------------------
// wbi_burst_splitter
//   Converts a burst command from a slave node into a sequence of classic
//   single-beat accesses on a downstream target bus. Each beat walks through
//   WAIT (beat ready?), REQ (strobe until target ack/err) and RESP (one-cycle
//   acknowledge back to the slave node).
//
// Parameters
//   AW  address width          BW  byte-enable width (also address step)
//   BL  burst-count width      DW  data width
//
// Ports
//   clk_i, rst_i            clock, asynchronous active-high reset
//   wbs_cyc_i, wbs_stb_i    burst cycle / strobe from slave node
//   wbs_adr_i, wbs_we_i     burst start address, direction
//   wbs_dat_i, wbs_sel_i    per-beat write data / byte enables
//   wbs_tid_i, wbs_bl_i     transaction id, burst length in beats
//   wbs_bry_i               beat ready
//   wbs_dat_o               read data of the acknowledged beat
//   wbs_ack_o, wbs_lack_o   beat acknowledge, last-beat qualifier
//   wbs_err_o               errored-beat qualifier
//   wbd_cyc_o, wbd_stb_o    classic cycle / strobe to target
//   wbd_adr_o, wbd_we_o     target address, write enable
//   wbd_dat_o, wbd_sel_o    target write data, byte enables
//   wbd_dat_i, wbd_ack_i    target read data, acknowledge
//   wbd_err_i               target error (terminates like ack)
// ---------------------------------------------------------------------------
module wbi_burst_splitter #(
  parameter int AW = 32,
  parameter int BW = 4,
  parameter int BL = 10,
  parameter int DW = 32
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          wbs_cyc_i,
  input  logic          wbs_stb_i,
  input  logic [AW-1:0] wbs_adr_i,
  input  logic          wbs_we_i,
  input  logic [DW-1:0] wbs_dat_i,
  input  logic [BW-1:0] wbs_sel_i,
  input  logic [3:0]    wbs_tid_i,
  input  logic [BL-1:0] wbs_bl_i,
  input  logic          wbs_bry_i,
  output logic [DW-1:0] wbs_dat_o,
  output logic          wbs_ack_o,
  output logic          wbs_lack_o,
  output logic          wbs_err_o,
  output logic          wbd_cyc_o,
  output logic          wbd_stb_o,
  output logic [AW-1:0] wbd_adr_o,
  output logic          wbd_we_o,
  output logic [DW-1:0] wbd_dat_o,
  output logic [BW-1:0] wbd_sel_o,
  input  logic [DW-1:0] wbd_dat_i,
  input  logic          wbd_ack_i,
  input  logic          wbd_err_i
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    REQ  = 2'd2,
    RESP = 2'd3
  } state_t;

  state_t        state;
  logic [BL-1:0] count;
  logic [3:0]    tid;

  // Single FSM; every output is a register updated on the transition that
  // enters the state in which it must be visible.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state      <= IDLE;
      count      <= '0;
      tid        <= '0;
      wbs_dat_o  <= '0;
      wbs_ack_o  <= 1'b0;
      wbs_lack_o <= 1'b0;
      wbs_err_o  <= 1'b0;
      wbd_cyc_o  <= 1'b0;
      wbd_stb_o  <= 1'b0;
      wbd_adr_o  <= '0;
      wbd_we_o   <= 1'b0;
      wbd_dat_o  <= '0;
      wbd_sel_o  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (wbs_cyc_i && wbs_stb_i) begin
            state     <= WAIT;
            wbd_adr_o <= wbs_adr_i;
            wbd_we_o  <= wbs_we_i;
            tid       <= wbs_tid_i;
            // A zero-length burst still performs one beat.
            count     <= (wbs_bl_i == '0) ? BL'(1) : wbs_bl_i;
            wbd_cyc_o <= 1'b1;
          end
        end
        WAIT: begin
          // Abort has priority over a ready beat.
          if (!wbs_cyc_i) begin
            state     <= IDLE;
            count     <= '0;
            wbd_cyc_o <= 1'b0;
          end else if (wbs_bry_i) begin
            state     <= REQ;
            wbd_dat_o <= wbs_dat_i;
            wbd_sel_o <= wbs_sel_i;
            wbd_stb_o <= 1'b1;
          end
        end
        REQ: begin
          // Error terminates the access exactly like an ack; it is only
          // reported, never used to cut the burst short.
          if (wbd_ack_i || wbd_err_i) begin
            state      <= RESP;
            wbd_stb_o  <= 1'b0;
            wbs_dat_o  <= wbd_dat_i;
            wbs_ack_o  <= 1'b1;
            wbs_err_o  <= wbd_err_i;
            wbs_lack_o <= (count == BL'(1));
          end
        end
        RESP: begin
          wbs_ack_o  <= 1'b0;
          wbs_err_o  <= 1'b0;
          wbs_lack_o <= 1'b0;
          count      <= count - BL'(1);
          // Address wraps naturally at 2^AW.
          wbd_adr_o  <= wbd_adr_o + AW'(BW);
          if (count == BL'(1)) begin
            state     <= IDLE;
            wbd_cyc_o <= 1'b0;
          end else begin
            state <= WAIT;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wbi_burst_splitter.sv
// ---------------------------------------------------------------------------
// tb_wbi_burst_splitter
//   Scoreboard bench. Each issued burst pushes the expected target accesses
//   and expected slave-side acknowledges into queues; a target model and a
//   slave monitor pop and compare as the DUT presents them.
// ---------------------------------------------------------------------------
module tb_wbi_burst_splitter;

  localparam int AW = 32;
  localparam int BW = 4;
  localparam int BL = 10;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          s_cyc = 1'b0, s_stb = 1'b0, s_we = 1'b0, s_bry = 1'b0;
  logic [AW-1:0] s_adr = '0;
  logic [DW-1:0] s_dat = '0;
  logic [BW-1:0] s_sel = '0;
  logic [3:0]    s_tid = '0;
  logic [BL-1:0] s_bl = '0;
  logic [DW-1:0] wbs_dat_o;
  logic          wbs_ack_o, wbs_lack_o, wbs_err_o;
  logic          wbd_cyc_o, wbd_stb_o, wbd_we_o;
  logic [AW-1:0] wbd_adr_o;
  logic [DW-1:0] wbd_dat_o;
  logic [BW-1:0] wbd_sel_o;
  logic [DW-1:0] t_dat = '0;
  logic          t_ack = 1'b0, t_err = 1'b0;

  wbi_burst_splitter #(.AW(AW), .BW(BW), .BL(BL), .DW(DW)) dut (
    .clk_i(clk), .rst_i(rst),
    .wbs_cyc_i(s_cyc), .wbs_stb_i(s_stb), .wbs_adr_i(s_adr), .wbs_we_i(s_we),
    .wbs_dat_i(s_dat), .wbs_sel_i(s_sel), .wbs_tid_i(s_tid), .wbs_bl_i(s_bl),
    .wbs_bry_i(s_bry),
    .wbs_dat_o(wbs_dat_o), .wbs_ack_o(wbs_ack_o), .wbs_lack_o(wbs_lack_o),
    .wbs_err_o(wbs_err_o),
    .wbd_cyc_o(wbd_cyc_o), .wbd_stb_o(wbd_stb_o), .wbd_adr_o(wbd_adr_o),
    .wbd_we_o(wbd_we_o), .wbd_dat_o(wbd_dat_o), .wbd_sel_o(wbd_sel_o),
    .wbd_dat_i(t_dat), .wbd_ack_i(t_ack), .wbd_err_i(t_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [AW-1:0] adr;
    logic          we;
    logic [DW-1:0] dat;
    logic [BW-1:0] sel;
  } tgt_exp_t;

  typedef struct packed {
    logic [DW-1:0] dat;
    logic          lack;
    logic          err;
  } slv_exp_t;

  tgt_exp_t tq[$];
  slv_exp_t sq[$];

  int compared = 0;
  int mismatched = 0;

  bit tgt_fast = 1'b0;   // ack in the first REQ cycle
  bit tgt_hold = 1'b0;   // never ack (used to park the DUT in REQ)
  bit err_all  = 1'b0;   // every access errors

  // Target behaviour, defined by the bench: read data and error are pure
  // functions of the accessed address.
  function automatic logic [DW-1:0] tgt_rd(input logic [AW-1:0] a);
    return a ^ 32'h5A5A_C3C3;
  endfunction

  function automatic logic tgt_err(input logic [AW-1:0] a);
    return err_all || (a[4:2] == 3'd5);
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Target model and target-side monitor.
  initial begin
    forever begin
      @(negedge clk);
      t_ack = 1'b0;
      t_err = 1'b0;
      if (!rst && wbd_stb_o && !tgt_hold && (tgt_fast || ($urandom % 2 == 0))) begin
        if (tq.size() == 0) begin
          check("unexpected_target_access", 128'(wbd_adr_o), 128'hDEAD);
        end else begin
          tgt_exp_t e;
          e = tq.pop_front();
          check("tgt_adr", 128'(wbd_adr_o), 128'(e.adr));
          check("tgt_we",  128'(wbd_we_o),  128'(e.we));
          check("tgt_dat", 128'(wbd_dat_o), 128'(e.dat));
          check("tgt_sel", 128'(wbd_sel_o), 128'(e.sel));
        end
        t_dat = tgt_rd(wbd_adr_o);
        if (tgt_err(wbd_adr_o)) t_err = 1'b1;
        else t_ack = 1'b1;
      end else if (!wbd_stb_o && ($urandom % 8 == 0)) begin
        // Stray terminations outside REQ must be ignored by the DUT.
        t_dat = $urandom;
        if ($urandom % 2 == 0) t_ack = 1'b1;
        else t_err = 1'b1;
      end
    end
  end

  // Slave-side monitor.
  always @(negedge clk) begin
    if (!rst) begin
      if (wbs_ack_o) begin
        if (sq.size() == 0) begin
          check("unexpected_ack", 128'(wbs_ack_o), 128'(0));
        end else begin
          slv_exp_t e;
          e = sq.pop_front();
          check("ack_dat",  128'(wbs_dat_o),  128'(e.dat));
          check("ack_lack", 128'(wbs_lack_o), 128'(e.lack));
          check("ack_err",  128'(wbs_err_o),  128'(e.err));
        end
      end else begin
        check("idle_qualifiers", 128'({wbs_lack_o, wbs_err_o}), 128'(0));
      end
    end
  end

  task automatic expect_burst(input logic [AW-1:0] a, input int n, input logic we,
                              input logic [DW-1:0] wd[$], input logic [BW-1:0] ws[$]);
    for (int i = 0; i < n; i++) begin
      logic [AW-1:0] ba;
      ba = a + AW'(BW * i);
      tq.push_back('{adr: ba, we: we, dat: wd[i], sel: ws[i]});
      sq.push_back('{dat: tgt_rd(ba), lack: (i == n - 1), err: tgt_err(ba)});
    end
  endtask

  // Drive one burst; bry_hold cycles of bry=0 are forced at the start, and
  // rnd_bry randomises bry thereafter.
  task automatic run_burst(input logic [AW-1:0] a, input int bl, input logic we,
                           input int bry_hold, input bit rnd_bry);
    logic [DW-1:0] wd[$];
    logic [BW-1:0] ws[$];
    int n, beats, cycles, hold;
    n = (bl == 0) ? 1 : bl;
    for (int i = 0; i < n; i++) begin
      wd.push_back($urandom);
      ws.push_back(BW'($urandom));
    end
    expect_burst(a, n, we, wd, ws);
    @(negedge clk);
    s_cyc = 1'b1; s_stb = 1'b1; s_adr = a; s_we = we; s_bl = BL'(bl);
    s_tid = 4'($urandom); s_dat = wd[0]; s_sel = ws[0];
    hold = bry_hold;
    s_bry = (hold > 0) ? 1'b0 : 1'b1;
    beats = 0; cycles = 0;
    while (beats < n && cycles < 2000) begin
      @(negedge clk);
      cycles++;
      if (wbs_ack_o) begin
        beats++;
        if (beats < n) begin
          s_dat = wd[beats]; s_sel = ws[beats];
          s_adr = $urandom; s_bl = BL'($urandom);
        end
      end
      if (hold > 0) begin
        check("bp_stb_low", 128'(wbd_stb_o), 128'(0));
        check("bp_cyc_high", 128'(wbd_cyc_o), 128'(1));
        hold--;
        s_bry = (hold == 0);
      end else begin
        s_bry = rnd_bry ? ($urandom % 3 != 0) : 1'b1;
      end
    end
    if (beats < n) check("burst_timeout", 128'(beats), 128'(n));
    s_cyc = 1'b0; s_stb = 1'b0; s_bry = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("cyc_released", 128'(wbd_cyc_o), 128'(0));
  endtask

  initial begin
    int cycles;
    // Reset state.
    #12;
    check("reset_outputs", 128'({wbs_dat_o, wbs_ack_o, wbs_lack_o, wbs_err_o, wbd_cyc_o,
          wbd_stb_o, wbd_adr_o, wbd_we_o, wbd_dat_o, wbd_sel_o}), 128'(0));
    @(negedge clk);
    rst = 1'b0;

    // Read burst, single-cycle target.
    tgt_fast = 1'b1;
    run_burst(32'h100, 4, 1'b0, 0, 1'b0);
    // Write burst of three beats.
    run_burst(32'h2000, 3, 1'b1, 0, 1'b0);
    // Backpressure: bry low for 5 cycles.
    run_burst(32'h40, 2, 1'b0, 5, 1'b0);
    // Error with zero length at the top address, then wrap.
    err_all = 1'b1;
    run_burst(32'hFFFF_FFFC, 0, 1'b0, 0, 1'b0);
    err_all = 1'b0;
    run_burst(32'hFFFF_FFFC, 2, 1'b1, 0, 1'b0);

    // Abort in WAIT: no target access and no ack may follow.
    @(negedge clk);
    s_cyc = 1'b1; s_stb = 1'b1; s_adr = 32'h500; s_bl = BL'(3); s_bry = 1'b0;
    repeat (3) @(negedge clk);
    s_cyc = 1'b0; s_stb = 1'b0;
    repeat (2) @(negedge clk);
    check("abort_cyc", 128'({wbd_cyc_o, wbd_stb_o}), 128'(0));

    // Reset in REQ of beat 2 of 4.
    begin
      logic [DW-1:0] wd[$];
      logic [BW-1:0] ws[$];
      for (int i = 0; i < 4; i++) begin
        wd.push_back($urandom);
        ws.push_back(BW'($urandom));
      end
      expect_burst(32'h800, 4, 1'b1, wd, ws);
      @(negedge clk);
      s_cyc = 1'b1; s_stb = 1'b1; s_adr = 32'h800; s_we = 1'b1; s_bl = BL'(4);
      s_dat = wd[0]; s_sel = ws[0]; s_bry = 1'b1;
      cycles = 0;
      while (!wbs_ack_o && cycles < 100) begin @(negedge clk); cycles++; end
      check("rst_first_ack", 128'(wbs_ack_o), 128'(1));
      tgt_hold = 1'b1;
      s_dat = wd[1]; s_sel = ws[1];
      cycles = 0;
      while (!wbd_stb_o && cycles < 100) begin @(negedge clk); cycles++; end
      check("rst_in_req", 128'(wbd_stb_o), 128'(1));
      check("rst_beat2_adr", 128'(wbd_adr_o), 128'(32'h804));
      #2 rst = 1'b1;
      #1 check("midburst_reset_outputs", 128'({wbs_dat_o, wbs_ack_o, wbs_lack_o, wbs_err_o,
            wbd_cyc_o, wbd_stb_o, wbd_adr_o, wbd_we_o, wbd_dat_o, wbd_sel_o}), 128'(0));
      tq.delete();
      sq.delete();
      s_cyc = 1'b0; s_stb = 1'b0; s_bry = 1'b0;
      tgt_hold = 1'b0;
      @(negedge clk);
      rst = 1'b0;
    end
    run_burst(32'hC00, 2, 1'b0, 0, 1'b0);

    // Randomised bursts with random target latency and bry.
    tgt_fast = 1'b0;
    for (int k = 0; k < 30; k++) begin
      run_burst($urandom, int'($urandom_range(0, 6)), 1'($urandom), 0, 1'b1);
    end

    repeat (4) @(negedge clk);
    check("tgt_queue_empty", 128'(tq.size()), 128'(0));
    check("slv_queue_empty", 128'(sq.size()), 128'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/wbi_burst_splitter.md
WBI_BURST_SPLITTER -- requirements
Module: wbi_burst_splitter

Interface
REQ-001 Parameters SHALL be: AW, default 32, address width; BW, default 4, byte-enable width; BL, default 10, burst-count width; DW, default 32, data width.
REQ-002 clk_i  input  1  system clock; all state changes on its rising edge.
REQ-003 rst_i  input  1  reset, asynchronous assert, active-high.
REQ-004 wbs_cyc_i  input  1  burst cycle from the slave node.
REQ-005 wbs_stb_i  input  1  burst strobe (command-FIFO non-empty).
REQ-006 wbs_adr_i  input  AW  byte address of the current command entry.
REQ-007 wbs_we_i  input  1  write=1, read=0.
REQ-008 wbs_dat_i  input  DW  write data of the current beat.
REQ-009 wbs_sel_i  input  BW  byte enables of the current beat.
REQ-010 wbs_tid_i  input  4  transaction id; carried, not interpreted.
REQ-011 wbs_bl_i  input  BL  burst length in beats.
REQ-012 wbs_bry_i  input  1  beat ready: write data present, or read-response space available.
REQ-013 wbs_dat_o  output  DW  read data of the acknowledged beat.
REQ-014 wbs_ack_o  output  1  one-cycle beat acknowledge.
REQ-015 wbs_lack_o  output  1  qualifies wbs_ack_o as the last beat.
REQ-016 wbs_err_o  output  1  qualifies wbs_ack_o as an errored beat.
REQ-017 wbd_cyc_o  output  1  classic single-access cycle to the target.
REQ-018 wbd_stb_o  output  1  classic strobe to the target.
REQ-019 wbd_adr_o  output  AW  target byte address.
REQ-020 wbd_we_o  output  1  target write enable.
REQ-021 wbd_dat_o  output  DW  target write data.
REQ-022 wbd_sel_o  output  BW  target byte enables.
REQ-023 wbd_dat_i  input  DW  target read data.
REQ-024 wbd_ack_i  input  1  target acknowledge.
REQ-025 wbd_err_i  input  1  target error; terminates an access exactly as wbd_ack_i does.

Function
REQ-026 The FSM SHALL have the states IDLE, WAIT, REQ and RESP.
REQ-027 IDLE with wbs_cyc_i&wbs_stb_i -> WAIT, latching adr, we, tid and count = wbs_bl_i; a wbs_bl_i of 0 SHALL be treated as 1.
REQ-028 WAIT: !wbs_cyc_i -> IDLE (abort, no ack); wbs_bry_i -> REQ, registering wbs_dat_i and wbs_sel_i into wbd_dat_o and wbd_sel_o.
REQ-029 REQ: wbd_stb_o=1; hold until wbd_ack_i|wbd_err_i, then -> RESP, registering wbd_dat_i into wbs_dat_o and wbd_err_i into the error flag.
REQ-030 RESP: wbs_ack_o=1 for exactly one cycle, wbs_err_o=error flag, wbs_lack_o=(count==1).
REQ-031 RESP exit: decrement count and advance adr by BW modulo 2^AW; if count was 1 -> IDLE, else -> WAIT.
REQ-032 Write data and sel SHALL be taken per beat from wbs_dat_i/wbs_sel_i; wbs_adr_i and wbs_bl_i of write beats after the first SHALL be ignored.
REQ-033 wbd_cyc_o SHALL be 1 in WAIT, REQ and RESP; wbd_stb_o SHALL be 1 only in REQ; wbd_adr_o and wbd_we_o SHALL be the latched values.
REQ-034 Latency: wbs_ack_o SHALL assert on the cycle after wbd_ack_i is sampled; minimum per-beat period is 3 cycles (WAIT, REQ, RESP).
REQ-035 An error SHALL NOT shorten a burst; every remaining beat is still issued.
REQ-036 Outside RESP, wbs_ack_o, wbs_lack_o and wbs_err_o SHALL be 0; wbs_dat_o SHALL hold its last value.
REQ-037 wbd_ack_i or wbd_err_i outside REQ SHALL be ignored.

Reset
REQ-038 rst_i SHALL force IDLE, count 0, and every output 0, at any time including mid-burst; no ack SHALL be generated for an aborted burst.

Verification
REQ-039 Read burst: adr=0x100, bl=4, bry=1, target acks in 1 cycle -> wbd_adr_o = 0x100/104/108/10C; 4 wbs_ack_o pulses; lack only on the 4th.
REQ-040 Write burst: bl=3, data A/B/C presented per ack -> target sees A@adr, B@adr+4, C@adr+8; 3 acks; lack on C.
REQ-041 bry backpressure: read bl=2, bry=0 for 5 cycles -> FSM stays in WAIT and wbd_stb_o=0 for those 5 cycles; completes after bry rises.
REQ-042 Error and wrap: bl=0 at adr=0xFFFFFFFC, wbd_err_i=1 -> one beat with ack, lack and err all 1, then IDLE; bl=2 from the same address -> second beat at adr 0x0.
REQ-043 Reset mid-burst: rst_i asserted in REQ of beat 2 of 4 -> all outputs 0 immediately; a new burst after release starts cleanly at its own address.
